// File: rtl/fir_pkg.sv
// ---------------------------------------------------------------------------
// fir_pkg
// Shared definitions for the serial (resource-folded) FIR filter family:
//   - fir_state_e : sequencer states of the folded filter
//   - DEF_*       : default sample / coefficient widths and tap count
//   - fir_owidth  : full-precision accumulator width for a given filter shape
// ---------------------------------------------------------------------------
package fir_pkg;

  // Sequencer states: wait for a sample, run the taps, publish the result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    DONE = 2'd2
  } fir_state_e;

  localparam int DEF_IWIDTH = 14;
  localparam int DEF_CWIDTH = 14;
  localparam int DEF_TAPS   = 50;

  // Accumulator width that cannot overflow: product bits plus growth for
  // summing 'taps' products.
  function automatic int fir_owidth(input int iw, input int cw, input int taps);
    return iw + cw + $clog2(taps);
  endfunction

endpackage

// File: rtl/fir_mac_unit.sv
// ---------------------------------------------------------------------------
// fir_mac_unit
// Registered signed multiply-accumulate with synchronous clear and enable.
// acc <= clr ? 0 : (en ? acc + sext(a*b) : acc)
//
// Ports:
//   clk    in   1    rising-edge clock
//   rst_n  in   1    asynchronous active-low reset, clears the accumulator
//   clr    in   1    synchronous clear (wins over en)
//   en     in   1    accumulate a*b this cycle
//   a      in   AW   signed multiplicand
//   b      in   BW   signed multiplier
//   acc    out  OW   signed accumulator (registered)
// ---------------------------------------------------------------------------
module fir_mac_unit #(
  parameter int AW = 14,
  parameter int BW = 14,
  parameter int OW = 34
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 en,
  input  logic signed [AW-1:0] a,
  input  logic signed [BW-1:0] b,
  output logic signed [OW-1:0] acc
);

  logic signed [AW+BW-1:0] a_ext_s;
  logic signed [AW+BW-1:0] b_ext_s;
  logic signed [AW+BW-1:0] prod_s;
  logic signed [OW-1:0]    prod_ext_s;
  logic signed [OW-1:0]    acc_r;

  // Full-precision signed product, sign-extended to the accumulator width.
  // Operands are widened first so the low AW+BW bits of the product are exact.
  always_comb begin
    a_ext_s    = {{BW{a[AW-1]}}, a};
    b_ext_s    = {{AW{b[BW-1]}}, b};
    prod_s     = a_ext_s * b_ext_s;
    prod_ext_s = {{(OW-AW-BW){prod_s[AW+BW-1]}}, prod_s};
  end

  // Accumulator register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r <= '0;
    end else if (clr) begin
      acc_r <= '0;
    end else if (en) begin
      acc_r <= acc_r + prod_ext_s;
    end else begin
      acc_r <= acc_r;
    end
  end

  assign acc = acc_r;

endmodule

// File: rtl/fir_serial_mac.sv
// ---------------------------------------------------------------------------
// fir_serial_mac
// Folded FIR filter: y[n] = sum_{k=0}^{TAPS-1} h[k]*x[n-k], computed with one
// shared multiply-accumulator stepping through a circular sample history.
// One output is produced per DECIM accepted samples. Coefficients are loaded
// at run time; clr zeroes the sample history.
//
// Ports:
//   clk        in   1       rising-edge clock
//   rst_n      in   1       asynchronous active-low reset
//   in_valid   in   1       in_data valid
//   in_ready   out  1       sample accepted on in_valid && in_ready
//   in_data    in   IWIDTH  signed input sample
//   clr        in   1       synchronous history clear (IDLE only)
//   coef_we    in   1       coefficient write strobe (IDLE, no handshake)
//   coef_addr  in   AWIDTH  coefficient index k (h[k] multiplies x[n-k])
//   coef_data  in   CWIDTH  signed coefficient value
//   out_valid  out  1       one-cycle strobe, out_data updated
//   out_data   out  OWIDTH  signed filter output, held until next result
//
// Timing: the accepting edge moves the sequencer to MAC; TAPS edges run the
// taps; the DONE edge registers the result, so out_valid is seen TAPS+1
// edges after acceptance and the next sample can be taken one edge later.
// ---------------------------------------------------------------------------
module fir_serial_mac
  import fir_pkg::*;
#(
  parameter  int IWIDTH = DEF_IWIDTH,
  parameter  int CWIDTH = DEF_CWIDTH,
  parameter  int TAPS   = DEF_TAPS,
  parameter  int DECIM  = 1,
  localparam int AWIDTH = $clog2(TAPS),
  localparam int OWIDTH = fir_owidth(IWIDTH, CWIDTH, TAPS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [IWIDTH-1:0] in_data,
  input  logic                     clr,
  input  logic                     coef_we,
  input  logic        [AWIDTH-1:0] coef_addr,
  input  logic signed [CWIDTH-1:0] coef_data,
  output logic                     out_valid,
  output logic signed [OWIDTH-1:0] out_data
);

  localparam int DWIDTH = (DECIM > 1) ? $clog2(DECIM) : 1;

  fir_state_e               state_r;
  fir_state_e               state_nxt_s;
  logic                     ready_r;
  logic        [AWIDTH-1:0] wr_ptr_r;
  logic        [AWIDTH-1:0] rd_ptr_r;
  logic        [AWIDTH-1:0] k_r;
  logic        [DWIDTH-1:0] dec_cnt_r;
  logic signed [IWIDTH-1:0] hist_r [TAPS];
  logic signed [CWIDTH-1:0] coef_r [TAPS];
  logic                     out_valid_r;
  logic signed [OWIDTH-1:0] out_data_r;
  logic signed [OWIDTH-1:0] acc_s;

  logic hs_s;
  logic clr_s;
  logic coef_wr_s;
  logic dec_wrap_s;
  logic start_s;
  logic last_tap_s;
  logic mac_en_s;

  // ready_r is only set while idle; clr masks it combinationally so a
  // coincident sample is refused in the same cycle the history is wiped.
  assign in_ready = ready_r & ~clr;

  // Handshake qualifiers and sequencer next state.
  always_comb begin
    hs_s        = 1'b0;
    clr_s       = 1'b0;
    coef_wr_s   = 1'b0;
    dec_wrap_s  = 1'b0;
    start_s     = 1'b0;
    last_tap_s  = 1'b0;
    mac_en_s    = 1'b0;
    state_nxt_s = state_r;

    hs_s       = in_valid & in_ready;
    clr_s      = clr & (state_r == IDLE);
    dec_wrap_s = (dec_cnt_r == DWIDTH'(DECIM - 1));
    start_s    = hs_s & dec_wrap_s;
    last_tap_s = (k_r == AWIDTH'(TAPS - 1));
    mac_en_s   = (state_r == MAC);
    // Addresses beyond the last tap are ignored rather than aliased.
    coef_wr_s  = coef_we & (state_r == IDLE) & ~hs_s &
                 ({1'b0, coef_addr} < (AWIDTH + 1)'(TAPS));

    case (state_r)
      IDLE: begin
        if (start_s) begin
          state_nxt_s = MAC;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      MAC: begin
        if (last_tap_s) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = MAC;
        end
      end
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Sequencer state and the ready flag (low during reset, high when idle).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      ready_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      ready_r <= (state_nxt_s == IDLE);
    end
  end

  // Write pointer and decimation phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r  <= '0;
      dec_cnt_r <= '0;
    end else if (clr_s) begin
      wr_ptr_r  <= '0;
      dec_cnt_r <= '0;
    end else if (hs_s) begin
      if (wr_ptr_r == AWIDTH'(TAPS - 1)) begin
        wr_ptr_r <= '0;
      end else begin
        wr_ptr_r <= wr_ptr_r + AWIDTH'(1);
      end
      if (dec_wrap_s) begin
        dec_cnt_r <= '0;
      end else begin
        dec_cnt_r <= dec_cnt_r + DWIDTH'(1);
      end
    end else begin
      wr_ptr_r  <= wr_ptr_r;
      dec_cnt_r <= dec_cnt_r;
    end
  end

  // Circular sample history; an empty history reads as zeros.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TAPS; i++) begin
        hist_r[i] <= '0;
      end
    end else if (clr_s) begin
      for (int i = 0; i < TAPS; i++) begin
        hist_r[i] <= '0;
      end
    end else if (hs_s) begin
      hist_r[wr_ptr_r] <= in_data;
    end else begin
      hist_r[wr_ptr_r] <= hist_r[wr_ptr_r];
    end
  end

  // Coefficient bank; writes land only between passes so a pass never sees
  // a mix of old and new coefficients.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TAPS; i++) begin
        coef_r[i] <= '0;
      end
    end else if (coef_wr_s) begin
      coef_r[coef_addr] <= coef_data;
    end else begin
      coef_r[coef_addr] <= coef_r[coef_addr];
    end
  end

  // Tap index and read pointer: start at the newest sample (the slot just
  // written) and walk backwards in time, wrapping below slot 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_r      <= '0;
      rd_ptr_r <= '0;
    end else if (start_s) begin
      k_r      <= '0;
      rd_ptr_r <= wr_ptr_r;
    end else if (mac_en_s) begin
      if (last_tap_s) begin
        k_r <= '0;
      end else begin
        k_r <= k_r + AWIDTH'(1);
      end
      if (rd_ptr_r == '0) begin
        rd_ptr_r <= AWIDTH'(TAPS - 1);
      end else begin
        rd_ptr_r <= rd_ptr_r - AWIDTH'(1);
      end
    end else begin
      k_r      <= k_r;
      rd_ptr_r <= rd_ptr_r;
    end
  end

  fir_mac_unit #(
    .AW (IWIDTH),
    .BW (CWIDTH),
    .OW (OWIDTH)
  ) u_mac (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (start_s),
    .en    (mac_en_s),
    .a     (hist_r[rd_ptr_r]),
    .b     (coef_r[k_r]),
    .acc   (acc_s)
  );

  // Result register: publish the finished sum and strobe for one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
    end else if (state_r == DONE) begin
      out_valid_r <= 1'b1;
      out_data_r  <= acc_s;
    end else begin
      out_valid_r <= 1'b0;
      out_data_r  <= out_data_r;
    end
  end

  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;

endmodule

// File: tb/tb_fir_serial_mac.sv
// ---------------------------------------------------------------------------
// tb_fir_serial_mac
// Two instances: dut_a (DECIM=1) and dut_b (DECIM=4). Stimulus tasks push the
// expected result of every sample that should produce an output into a
// per-instance queue; monitors pop and compare whenever out_valid is seen,
// including the acceptance-to-output latency.
// ---------------------------------------------------------------------------
module tb_fir_serial_mac;

  localparam int TAPS = 50;
  localparam int IW   = 14;
  localparam int CW   = 14;
  localparam int AW   = 6;
  localparam int OW   = 34;
  localparam longint LAT = (TAPS + 1) * 10 + 5;  // accept edge -> sampling negedge

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst_n;
  logic                 a_in_valid, a_in_ready, a_clr, a_coef_we, a_out_valid;
  logic signed [IW-1:0] a_in_data;
  logic        [AW-1:0] a_coef_addr;
  logic signed [CW-1:0] a_coef_data;
  logic signed [OW-1:0] a_out_data;
  logic                 b_in_valid, b_in_ready, b_clr, b_coef_we, b_out_valid;
  logic signed [IW-1:0] b_in_data;
  logic        [AW-1:0] b_coef_addr;
  logic signed [CW-1:0] b_coef_data;
  logic signed [OW-1:0] b_out_data;

  fir_serial_mac #(.IWIDTH(IW), .CWIDTH(CW), .TAPS(TAPS), .DECIM(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .clr(a_clr), .coef_we(a_coef_we), .coef_addr(a_coef_addr),
    .coef_data(a_coef_data), .out_valid(a_out_valid), .out_data(a_out_data));

  fir_serial_mac #(.IWIDTH(IW), .CWIDTH(CW), .TAPS(TAPS), .DECIM(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .clr(b_clr), .coef_we(b_coef_we), .coef_addr(b_coef_addr),
    .coef_data(b_coef_data), .out_valid(b_out_valid), .out_data(b_out_data));

  typedef struct {
    longint val;
    time    t;
  } exp_t;

  exp_t   qa[$];
  exp_t   qb[$];
  int     total = 0;
  int     bad = 0;
  int     b_pulses = 0;
  int     b_cnt = 0;
  longint xa[TAPS];
  longint ha[TAPS];
  longint xb[TAPS];
  longint hb[TAPS];

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic longint conv_a();
    longint s = 0;
    for (int k = 0; k < TAPS; k++) s += ha[k] * xa[k];
    return s;
  endfunction

  function automatic longint conv_b();
    longint s = 0;
    for (int k = 0; k < TAPS; k++) s += hb[k] * xb[k];
    return s;
  endfunction

  // Reference history: index 0 is the newest sample.
  task automatic model_push(input int which, input longint x, input bit use_hand,
                            input longint hand, input time t, input bit expect_out);
    exp_t e;
    e.t = t;
    if (which == 0) begin
      for (int k = TAPS - 1; k > 0; k--) xa[k] = xa[k-1];
      xa[0] = x;
      e.val = use_hand ? hand : conv_a();
      if (expect_out) qa.push_back(e);
    end else begin
      for (int k = TAPS - 1; k > 0; k--) xb[k] = xb[k-1];
      xb[0] = x;
      b_cnt++;
      if (b_cnt == 4) begin
        b_cnt = 0;
        e.val = conv_b();
        qb.push_back(e);
      end
    end
  endtask

  task automatic send(input int which, input longint x, input bit use_hand,
                      input longint hand, input bit expect_out, output time t_acc);
    bit ok = 0;
    t_acc = 0;
    @(negedge clk);
    if (which == 0) begin a_in_valid = 1'b1; a_in_data = IW'(x); end
    else            begin b_in_valid = 1'b1; b_in_data = IW'(x); end
    for (int i = 0; i < 300; i++) begin
      #1;
      if ((which == 0) ? a_in_ready : b_in_ready) begin
        @(posedge clk);
        t_acc = $time;
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    if (ok) begin
      model_push(which, x, use_hand, hand, t_acc, expect_out);
    end else begin
      total++;
      bad++;
      $display("FAIL accept_timeout: dut %0d sample %0d not accepted", which, x);
      if (which == 0) a_in_valid = 1'b0; else b_in_valid = 1'b0;
    end
  endtask

  task automatic drop(input int which);
    @(negedge clk);
    if (which == 0) a_in_valid = 1'b0; else b_in_valid = 1'b0;
  endtask

  task automatic load_coef(input int which, input int k, input longint v);
    @(negedge clk);
    if (which == 0) begin
      a_coef_we = 1'b1; a_coef_addr = AW'(k); a_coef_data = CW'(v); ha[k] = v;
    end else begin
      b_coef_we = 1'b1; b_coef_addr = AW'(k); b_coef_data = CW'(v); hb[k] = v;
    end
    @(posedge clk);
    #1;
    a_coef_we = 1'b0;
    b_coef_we = 1'b0;
  endtask

  task automatic clr_a();
    @(negedge clk);
    a_clr = 1'b1;
    @(posedge clk);
    #1;
    a_clr = 1'b0;
    for (int k = 0; k < TAPS; k++) xa[k] = 0;
  endtask

  task automatic drain(input int which);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (((which == 0) ? qa.size() : qb.size()) == 0) break;
    end
    chk((which == 0) ? "a_drain" : "b_drain", (which == 0) ? qa.size() : qb.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  exp_t ea;
  // Monitor for dut_a.
  always @(negedge clk) begin
    if (a_out_valid) begin
      if (qa.size() == 0) begin
        total++;
        bad++;
        $display("FAIL a_unexpected_out: got out_valid data %0d, required no output", a_out_data);
      end else begin
        ea = qa.pop_front();
        chk("a_out_data", a_out_data, ea.val);
        chk("a_latency", longint'($time - ea.t), LAT);
      end
    end
  end

  exp_t eb;
  // Monitor for dut_b.
  always @(negedge clk) begin
    if (b_out_valid) begin
      b_pulses++;
      if (qb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL b_unexpected_out: got out_valid data %0d, required no output", b_out_data);
      end else begin
        eb = qb.pop_front();
        chk("b_out_data", b_out_data, eb.val);
        chk("b_latency", longint'($time - eb.t), LAT);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    time t, tprev;
    rst_n = 1'b0;
    a_in_valid = 1'b0; a_in_data = '0; a_clr = 1'b0; a_coef_we = 1'b0; a_coef_addr = '0; a_coef_data = '0;
    b_in_valid = 1'b0; b_in_data = '0; b_clr = 1'b0; b_coef_we = 1'b0; b_coef_addr = '0; b_coef_data = '0;

    // Reset state.
    #23;
    chk("rst_in_ready", a_in_ready, 0);
    chk("rst_out_valid", a_out_valid, 0);
    chk("rst_out_data", a_out_data, 0);
    chk("rst_b_in_ready", b_in_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("ready_before_first_edge", a_in_ready, 0);
    @(posedge clk);
    #1;
    chk("ready_after_first_edge", a_in_ready, 1);

    // Impulse response: h[k]=120*(k+1).
    for (int k = 0; k < TAPS; k++) load_coef(0, k, 120 * (k + 1));
    send(0, 1, 1, 120, 1, t);
    for (int i = 1; i < TAPS; i++) send(0, 0, 1, 120 * (i + 1), 1, t);
    send(0, 0, 1, 0, 1, t);
    drop(0);
    drain(0);

    // Signed extremes: output n = (n+1)*67108864, last = 3355443200.
    clr_a();
    for (int k = 0; k < TAPS; k++) load_coef(0, k, -8192);
    for (int i = 0; i < TAPS; i++) send(0, -8192, 1, longint'(i + 1) * 67108864, 1, t);
    drop(0);
    drain(0);
    chk("extreme_final_hold", a_out_data, 64'sd3355443200);

    // Backpressure: in_valid held high, one acceptance per TAPS+2 cycles.
    clr_a();
    for (int k = 0; k < TAPS; k++) load_coef(0, k, k - 25);
    tprev = 0;
    for (int i = 0; i < 10; i++) begin
      send(0, i * 613 - 2900, 0, 0, 1, t);
      if (i > 0) chk("bp_spacing", longint'(t - tprev), 520);
      tprev = t;
    end
    drop(0);
    drain(0);

    // Coefficient write during MAC is dropped; the same write in IDLE sticks.
    send(0, 777, 0, 0, 1, t);
    drop(0);
    repeat (5) @(negedge clk);
    a_coef_we = 1'b1; a_coef_addr = '0; a_coef_data = 14'sd1000;
    @(negedge clk);
    a_coef_we = 1'b0;
    drain(0);
    load_coef(0, 0, 1000);
    send(0, -555, 0, 0, 1, t);
    drop(0);
    drain(0);

    // clr beats a coincident in_valid: sample refused, history zeroed.
    @(negedge clk);
    a_clr = 1'b1; a_in_valid = 1'b1; a_in_data = 14'sd4000;
    #1;
    chk("clr_blocks_ready", a_in_ready, 0);
    @(posedge clk);
    #1;
    a_in_valid = 1'b0;
    a_clr = 1'b0;
    for (int k = 0; k < TAPS; k++) xa[k] = 0;
    send(0, 100, 0, 0, 1, t);
    send(0, -200, 0, 0, 1, t);
    send(0, 300, 0, 0, 1, t);
    drop(0);
    drain(0);

    // Reset at k=20 of a pass: no output for that sample, everything cleared.
    send(0, 1234, 0, 0, 0, t);
    repeat (20) @(posedge clk);
    #2;
    rst_n = 1'b0;
    a_in_valid = 1'b0;
    #1;
    chk("midrst_out_valid", a_out_valid, 0);
    chk("midrst_out_data", a_out_data, 0);
    chk("midrst_in_ready", a_in_ready, 0);
    for (int k = 0; k < TAPS; k++) begin
      xa[k] = 0; ha[k] = 0; xb[k] = 0; hb[k] = 0;
    end
    b_cnt = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    chk("postrst_out_data", a_out_data, 0);
    load_coef(0, 0, 3);
    load_coef(0, 1, -2);
    load_coef(0, 2, 5);
    load_coef(0, 3, 7);
    load_coef(0, 4, -1);
    for (int i = 0; i < 6; i++) send(0, 1000 - i * 450, 0, 0, 1, t);
    drop(0);
    drain(0);

    // Decimation by 4 on a 0..199 ramp: outputs after samples 3, 7, 11, ...
    for (int k = 0; k < TAPS; k++) load_coef(1, k, (k % 9) - 4);
    for (int i = 0; i < 200; i++) send(1, i, 0, 0, 1, t);
    drop(1);
    drain(1);
    chk("b_pulse_count", b_pulses, 50);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
